i2s_rx: RTL and testbench

- Receives a standard Philips I2S audio stream from an external ADC or codec and delivers parallel left/right samples in the clk_sys domain.
- It is the receive counterpart of the core's I2S transmitter and feeds line-in / tape audio into the core.
- The serial clock and word select are treated as asynchronous data inputs and are oversampled by clk_sys. No second clock domain exists.

---
 rtl/i2s_rx.sv | 215 +++++++++++++++++++++
 tb/tb_i2s_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
`default_nettype none
//==============================================================================
// Module   : i2s_rx
// Purpose  : Philips I2S receiver oversampled by clk_sys; emits paired L/R
//            samples. Optional bit-clock loss detection via I2S_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
module i2s_rx #(
    parameter int DATA_BITS      = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic                 lrclk,
    input  logic                 sdata,
    output logic [DATA_BITS-1:0] left_chan,
    output logic [DATA_BITS-1:0] right_chan,
    output logic                 sample_valid,
    output logic                 frame_err,
    output logic                 link_lost
);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [6:0] c_data_bits = 7'(DATA_BITS);

    logic [1:0]             r_rst_pipe;
    logic                   w_rst;
    logic [SYNC_STAGES-1:0] r_sclk_pipe;
    logic [SYNC_STAGES-1:0] r_lr_pipe;
    logic [SYNC_STAGES-1:0] r_sd_pipe;
    logic                   r_sclk_d;
    logic                   r_lr_prev;
    logic                   w_bit_evt;
    logic                   w_lr;
    logic                   w_sd;
    logic                   w_boundary;
    logic                   w_r2l;
    logic                   w_timeout;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_in;
    logic [DATA_BITS-1:0]   w_word;
    logic [DATA_BITS-1:0]   r_held_left;
    logic [DATA_BITS-1:0]   r_word;
    logic [DATA_BITS-1:0]   r_left;
    logic [DATA_BITS-1:0]   r_right;
    logic [5:0]             r_bitcnt;
    logic [5:0]             w_cnt_in;
    logic [5:0]             r_left_len;
    logic [6:0]             w_len_clip;
    logic [6:0]             w_shamt;
    logic                   r_pend;
    logic                   r_err_pend;
    logic                   r_valid;
    logic                   r_err;

    // Reset asserts asynchronously but releases on a clk_sys edge
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_rst_pipe <= 2'b11;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b0};
        end
    end
    assign w_rst = r_rst_pipe[1];

    always_ff @(posedge clk_sys or posedge w_rst) begin
        if (w_rst) begin
            r_sclk_pipe <= '0;
            r_lr_pipe   <= '0;
            r_sd_pipe   <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_pipe <= {r_sclk_pipe[SYNC_STAGES-2:0], sclk};
            r_lr_pipe   <= {r_lr_pipe[SYNC_STAGES-2:0], lrclk};
            r_sd_pipe   <= {r_sd_pipe[SYNC_STAGES-2:0], sdata};
            r_sclk_d    <= r_sclk_pipe[SYNC_STAGES-1];
        end
    end

    assign w_bit_evt  = r_sclk_pipe[SYNC_STAGES-1] & ~r_sclk_d;
    assign w_lr       = r_lr_pipe[SYNC_STAGES-1];
    assign w_sd       = r_sd_pipe[SYNC_STAGES-1];
    assign w_boundary = w_bit_evt & (w_lr != r_lr_prev);
    assign w_r2l      = w_boundary & r_lr_prev & ~w_lr;

    // The boundary bit is the ending word's LSB, so shift it in before finalizing
    assign w_cnt_in   = (r_bitcnt == 6'd63) ? r_bitcnt : r_bitcnt + 6'd1;
    assign w_shift_in = ({1'b0, r_bitcnt} < c_data_bits) ?
                        {r_shift[DATA_BITS-2:0], w_sd} : r_shift;
    assign w_len_clip = ({1'b0, w_cnt_in} < c_data_bits) ? {1'b0, w_cnt_in} : c_data_bits;
    assign w_shamt    = c_data_bits - w_len_clip;
    assign w_word     = w_shift_in << w_shamt;

`ifdef I2S_RX_TIMEOUT_EN
    localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;
    logic        r_link_lost;

    always_ff @(posedge clk_sys or posedge w_rst) begin
        if (w_rst) begin
            r_to_cnt <= '0;
        end else if (w_bit_evt) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != 16'hFFFF) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_timeout = ~w_bit_evt & (r_to_cnt == c_to_last);

    always_ff @(posedge clk_sys or posedge w_rst) begin
        if (w_rst) begin
            r_link_lost <= 1'b0;
        end else if (w_timeout) begin
            r_link_lost <= 1'b1;
        end else if (r_pend) begin
            r_link_lost <= 1'b0;
        end
    end
    assign link_lost = r_link_lost;
`else
    assign w_timeout = 1'b0;
    assign link_lost = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge w_rst) begin
        if (w_rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HUNT:    if (w_r2l) w_state_next = RUN;
            RUN:     if (w_timeout) w_state_next = HUNT;
            default: w_state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk_sys or posedge w_rst) begin
        if (w_rst) begin
            r_lr_prev   <= 1'b0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_held_left <= '0;
            r_left_len  <= '0;
            r_word      <= '0;
            r_pend      <= 1'b0;
            r_err_pend  <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_bit_evt) begin
                r_lr_prev <= w_lr;
            end
            if (r_pend) begin
                r_left  <= r_held_left;
                r_right <= r_word;
                r_valid <= 1'b1;
                r_err   <= r_err_pend;
                r_pend  <= 1'b0;
            end
            if (r_state == RUN && w_bit_evt) begin
                if (w_boundary) begin
                    r_shift  <= '0;
                    r_bitcnt <= '0;
                    if (w_lr) begin
                        r_held_left <= w_word;
                        r_left_len  <= w_cnt_in;
                    end else begin
                        r_word     <= w_word;
                        r_err_pend <= (w_cnt_in != r_left_len);
                        r_pend     <= 1'b1;
                    end
                end else begin
                    r_shift  <= w_shift_in;
                    r_bitcnt <= w_cnt_in;
                end
            end else if (w_r2l) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
            end
            if (w_timeout) begin
                r_left   <= '0;
                r_right  <= '0;
                r_shift  <= '0;
                r_bitcnt <= '0;
                r_pend   <= 1'b0;
            end
        end
    end

    assign left_chan    = r_left;
    assign right_chan   = r_right;
    assign sample_valid = r_valid;
    assign frame_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
//==============================================================================
// Module   : tb_i2s_rx
// Purpose  : Scoreboard bench for i2s_rx driven by directed I2S frames.
// Revision : 1.0 - initial release
//==============================================================================
module tb_i2s_rx;

    localparam int DATA_BITS      = 16;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 64;

    logic                 clk_sys = 1'b0;
    logic                 reset   = 1'b1;
    logic                 sclk    = 1'b0;
    logic                 lrclk   = 1'b0;
    logic                 sdata   = 1'b0;
    logic [DATA_BITS-1:0] left_chan;
    logic [DATA_BITS-1:0] right_chan;
    logic                 sample_valid;
    logic                 frame_err;
    logic                 link_lost;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        e;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    time  t_rlsb = 0;
    time  t_last = 0;

    i2s_rx #(
        .DATA_BITS      (DATA_BITS),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .link_lost    (link_lost)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // One sclk period of 16 clk_sys cycles; data and lrclk change while sclk is low
    task automatic send_bit(input logic lr, input logic b, input logic mark);
        @(negedge clk_sys);
        sclk  = 1'b0;
        lrclk = lr;
        sdata = b;
        repeat (8) @(negedge clk_sys);
        sclk   = 1'b1;
        t_last = $time;
        if (mark) t_rlsb = $time;
        repeat (7) @(negedge clk_sys);
    endtask

    // lrclk switches one bit early, so the slot's LSB already carries lr_next
    task automatic send_slot(input logic lr_this, input logic lr_next,
                             input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit((i == 0) ? lr_next : lr_this, data[i],
                     (i == 0) && lr_this && !lr_next);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input int ln,
                              input logic [31:0] r, input int rn,
                              input logic [15:0] el, input logic [15:0] er,
                              input logic ee);
        exp_t x;
        x.l = el;
        x.r = er;
        x.e = ee;
        sb.push_back(x);
        send_slot(1'b0, 1'b1, l, ln);
        send_slot(1'b1, 1'b0, r, rn);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk_sys);
        check(name, sb.size(), 0);
    endtask

    always @(negedge clk_sys) begin
        if (sample_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: actual L=%0h R=%0h required no pulse",
                         left_chan, right_chan);
            end else begin
                e_mon = sb.pop_front();
                check("left_chan", 32'(left_chan), 32'(e_mon.l));
                check("right_chan", 32'(right_chan), 32'(e_mon.r));
                check("frame_err", 32'(frame_err), 32'(e_mon.e));
                check("latency", 32'($time - t_rlsb), 32'(10 * (SYNC_STAGES + 2)));
                check("link_lost_at_valid", 32'(link_lost), 32'd0);
            end
        end
        if (frame_err && !sample_valid) begin
            checks++;
            errors++;
            $display("FAIL frame_err_alone: actual 1 required 0");
        end
    end

    logic [15:0] r_word_tmp;

    initial begin
        repeat (4) @(negedge clk_sys);
        check("rst_left", 32'(left_chan), 32'd0);
        check("rst_right", 32'(right_chan), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_link_lost", 32'(link_lost), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);

        // Partial frame before the first right->left boundary is discarded
        send_slot(1'b0, 1'b1, 32'h1F, 5);
        send_slot(1'b1, 1'b0, 32'hBEEF, 16);
        send_frame(32'h1234, 16, 32'hABCD, 16, 16'h1234, 16'hABCD, 1'b0);
        send_frame(32'h7FFF00, 24, 32'h800001, 24, 16'h7FFF, 16'h8000, 1'b0);
        send_frame(32'h5A, 8, 32'hC3, 8, 16'h5A00, 16'hC300, 1'b0);
        send_frame(32'h1111, 16, 32'h2AAAA, 18, 16'h1111, 16'hAAAA, 1'b1);

        // Reset halfway through the right slot
        send_slot(1'b0, 1'b1, 32'h1234, 16);
        r_word_tmp = 16'h5555;
        for (int i = 15; i >= 8; i--) send_bit(1'b1, r_word_tmp[i], 1'b0);
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check("async_rst_left", 32'(left_chan), 32'd0);
        check("async_rst_right", 32'(right_chan), 32'd0);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit((i == 0) ? 1'b0 : 1'b1, r_word_tmp[i], 1'b0);
        send_frame(32'hCAFE, 16, 32'h0F0F, 16, 16'hCAFE, 16'h0F0F, 1'b0);

        // 1-bit slots: MSB left-aligned with zero fill
        send_frame(32'h1, 1, 32'h0, 1, 16'h8000, 16'h0000, 1'b0);
        drain("scoreboard_drained");

`ifdef I2S_RX_TIMEOUT_EN
        for (int i = 0; i < 2000 && !link_lost; i++) @(negedge clk_sys);
        check("link_lost_set", 32'(link_lost), 32'd1);
        check("timeout_delay", 32'($time - t_last),
              32'(10 * (SYNC_STAGES + TIMEOUT_CYCLES + 1)));
        check("timeout_left", 32'(left_chan), 32'd0);
        check("timeout_right", 32'(right_chan), 32'd0);
        send_slot(1'b0, 1'b1, 32'h0, 16);
        send_slot(1'b1, 1'b0, 32'h0, 16);
        check("link_lost_held", 32'(link_lost), 32'd1);
        send_frame(32'h0102, 16, 32'h0304, 16, 16'h0102, 16'h0304, 1'b0);
        drain("recovery_drained");
        check("link_lost_cleared", 32'(link_lost), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
